seg_scan_ctrl: RTL and testbench

Memory-mapped 4-digit seven-segment scan controller, directly downstream of the data-memory MMIO decoder.
- Takes the decoder's register-write strobe and data, plus its raw AN/BCD register outputs.
- Double-buffers the display word and time-multiplexes four digits with anti-ghost blanking.
- Drives active-low anodes and segments to the board.
- Raw mode forwards the software-written AN/BCD bits unchanged.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_hex_decoder.sv | 13 +
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, display-word layout and hex-to-segment table for the
// seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam int unsigned VAL_LSB = 0;
  localparam int unsigned EN_LSB  = 16;
  localparam int unsigned DP_LSB  = 20;
  localparam int unsigned RAW_BIT = 24;
  localparam int unsigned WORD_W  = RAW_BIT + 1;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    MODE_DECODED = 1'b0,
    MODE_RAW     = 1'b1
  } disp_mode_e;

  // Bit layout matches wr_data[24:0].
  typedef struct packed {
    logic        raw;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [15:0] val;
  } disp_word_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex to active-low 7-segment lookup.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit seven-segment scan controller with frame-aligned double buffering.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading-zero digits).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  raw_an,
  input  logic [7:0]  raw_bcd,
  output logic [3:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_q, digit_d;
  disp_word_t       shadow_q, shadow_d;
  disp_word_t       active_q, active_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick_q, tick_d;

  disp_word_t       wr_word;
  disp_mode_e       mode;
  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [6:0]       hex_seg_n;
  logic [3:0]       lz_dark;
  logic             digit_dark;
  logic             unused_wr_bits;

  assign wr_word        = disp_word_t'(wr_data[WORD_W-1:0]);
  assign unused_wr_bits = ^wr_data[31:WORD_W];
  assign mode           = disp_mode_e'(active_q.raw);
  assign slot_end       = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end      = slot_end && (digit_q == 2'd3);
  assign nibble         = active_q.val[{digit_q, 2'b00} +: 4];

  seg_hex_decoder u_hex (
    .nibble_i (nibble),
    .seg_n_o  (hex_seg_n)
  );

  always_comb begin
    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    digit_d   = slot_end ? digit_q + 2'd1 : digit_q;
  end

  // A write landing on the boundary cycle goes straight to the active word so
  // it is not held back a whole frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wr_en) begin
      shadow_d  = wr_word;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      if (wr_en) begin
        active_d = wr_word;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    lz_dark = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      lz_dark[i] = ((active_q.val >> (4 * i)) == 16'h0000);
    end
`endif
  end

  always_comb begin
    digit_dark = (div_cnt_q < CNT_W'(BLANK_CYCLES))
              || !active_q.en[digit_q]
              || lz_dark[digit_q];
  end

  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    tick_d = frame_end;
    if (mode == MODE_RAW) begin
      an_d  = raw_an;
      seg_d = raw_bcd;
    end else if (!digit_dark) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = {~active_q.dp[digit_q], hex_seg_n};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      digit_q   <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign an_o       = an_q;
  assign seg_o      = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a cycle-count based display model.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLK   = 2;
  localparam int unsigned FRAME = 4 * DIV;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  raw_an;
  logic [7:0]  raw_bcd;
  logic [3:0]  an_o;
  logic [7:0]  seg_o;
  logic        frame_tick;

  int unsigned n_cmp;
  int unsigned n_bad;
  string       phase;

  // Model state: m_n is the number of clock edges since reset release.
  int unsigned m_n;
  logic [24:0] m_shadow;
  logic [24:0] m_active;
  bit          m_pending;

  seg_scan_ctrl #(
    .SCAN_DIV     (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .raw_an     (raw_an),
    .raw_bcd    (raw_bcd),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, seg} for the display state reached after cycle n.
  function automatic logic [11:0] model_out(input int unsigned n, input logic [24:0] act,
                                            input logic [3:0] ran, input logic [7:0] rb);
    int unsigned pos, d, off;
    logic [15:0] val;
    logic [3:0]  nib;
    bit          lz;
    if (act[24]) return {ran, rb};
    pos = n % FRAME;
    d   = pos / DIV;
    off = pos % DIV;
    val = act[15:0];
    nib = 4'((val >> (4 * d)) & 16'h000F);
    lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz  = (d != 0) && ((val >> (4 * d)) == 16'h0000);
`endif
    if (off < BLK || !act[16 + d] || lz) return 12'hFFF;
    return {~(4'b0001 << d), ~act[20 + d], HEX[nib]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, expv);
    end
  endtask

  task automatic step();
    logic [11:0] e;
    logic        et;
    logic [24:0] w;
    e  = model_out(m_n, m_active, raw_an, raw_bcd);
    et = ((m_n % FRAME) == FRAME - 1);
    w  = wr_data[24:0];
    if (wr_en) begin
      m_shadow  = w;
      m_pending = 1'b1;
    end
    if (et) begin
      if (wr_en) m_active = w;
      else if (m_pending) m_active = m_shadow;
      m_pending = 1'b0;
    end
    m_n++;
    @(posedge clk);
    #1;
    chk("an", 32'(an_o), 32'(e[11:8]));
    chk("seg", 32'(seg_o), 32'(e[7:0]));
    chk("tick", 32'(frame_tick), 32'(et));
    wr_en = 1'b0;
  endtask

  task automatic write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
  endtask

  // Steps at least once, stopping when the model's frame position equals pos.
  task automatic advance_to(input int unsigned pos);
    do step(); while ((m_n % FRAME) != pos);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_an", 32'(an_o), 32'h0000000F);
    chk("rst_seg", 32'(seg_o), 32'h000000FF);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_an_hold", 32'(an_o), 32'h0000000F);
    chk("rst_seg_hold", 32'(seg_o), 32'h000000FF);
    wr_en     = 1'b0;
    reset     = 1'b0;
    m_n       = 0;
    m_shadow  = '0;
    m_active  = '0;
    m_pending = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    raw_an  = '0;
    raw_bcd = '0;

    phase = "reset";
    do_reset();

    phase = "idle";
    repeat (100) step();

    phase = "decode";
    write(32'h000F1234);
    advance_to(0);
    advance_to(BLK);
    step();
    chk("d0_an", 32'(an_o), 32'h0000000E);
    chk("d0_seg", 32'(seg_o), 32'h00000099);
    advance_to(3 * DIV + BLK);
    step();
    chk("d3_an", 32'(an_o), 32'h00000007);
    chk("d3_seg", 32'(seg_o), 32'h000000F9);

    phase = "lastwin";
    advance_to(5);
    write(32'h000F1111);
    advance_to(20);
    write(32'h000F2222);
    advance_to(0);
    advance_to(BLK);
    step();
    chk("lw_seg", 32'(seg_o), 32'h000000A4);
    advance_to(FRAME - 1);
    write(32'h000F5678);
    advance_to(BLK);
    step();
    chk("bnd_seg", 32'(seg_o), 32'h00000080);

    phase = "raw";
    raw_an  = 4'h1;
    raw_bcd = 8'hA5;
    write(32'h01000000);
    advance_to(0);
    step();
    chk("raw_an", 32'(an_o), 32'h00000001);
    chk("raw_seg", 32'(seg_o), 32'h000000A5);
    raw_bcd = 8'h3C;
    step();
    chk("raw_seg2", 32'(seg_o), 32'h0000003C);
    repeat (40) begin
      raw_an  = 4'($urandom);
      raw_bcd = 8'($urandom);
      step();
    end

    phase = "midreset";
    write(32'h000F1234);
    advance_to(0);
    advance_to(3);
    step();
    chk("pre_an", 32'(an_o), 32'h0000000E);
    write(32'h000F8888);
    do_reset();
    repeat (40) step();
    chk("post_an", 32'(an_o), 32'h0000000F);

    phase = "lzb";
    write(32'h000F0042);
    advance_to(0);
    repeat (FRAME) step();
    write(32'h000F0000);
    advance_to(0);
    repeat (FRAME) step();
    write(32'h00F50107);
    advance_to(0);
    repeat (FRAME) step();

    phase = "random";
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) begin
        wr_en       = 1'b1;
        wr_data     = $urandom;
        wr_data[24] = ($urandom_range(0, 3) == 0);
      end
      raw_an  = 4'($urandom);
      raw_bcd = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
